yari_mem_arbiter: RTL

Two-into-one memory arbiter that lets the yari core's instruction port and data port share a single external memory port. It sits between the core's `imem_req`/`imem_res` and `dmem_req`/`dmem_res` ports and one pipeconnect-style slave. It applies data-priority arbitration with a starvation guard, and locks the grant while the slave stalls so the presented request stays stable. It records the issuer of every accepted read in an in-order ID FIFO and routes each read response back to its issuer.

---
 rtl/yari_mem_arbiter_if.sv | 45 ++++
 rtl/yari_mem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/yari_mem_arbiter_if.sv
// Signal bundle around the two-into-one memory arbiter: the core's I and D
// ports and the shared pipeconnect-style memory port.
//   master : the environment (core I/D ports and the external memory slave)
//   slave  : the arbiter itself
//   i_*    : I-side read port        d_* : D-side read/write port
//   s_*    : shared memory port (request out of the arbiter, response into it)
interface yari_mem_arbiter_if;
    logic [29:0] i_addr;
    logic        i_rd;
    logic        i_hold;
    logic [31:0] i_rddata;
    logic        i_rddata_valid;

    logic [29:0] d_addr;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_wrdata;
    logic [3:0]  d_wrmask;
    logic        d_hold;
    logic [31:0] d_rddata;
    logic        d_rddata_valid;

    logic [29:0] s_addr;
    logic        s_rd;
    logic        s_wr;
    logic [31:0] s_wrdata;
    logic [3:0]  s_wrmask;
    logic        s_hold;
    logic [31:0] s_rddata;
    logic        s_rddata_valid;

    modport master (
        output i_addr, i_rd, d_addr, d_rd, d_wr, d_wrdata, d_wrmask,
               s_hold, s_rddata, s_rddata_valid,
        input  i_hold, i_rddata, i_rddata_valid, d_hold, d_rddata, d_rddata_valid,
               s_addr, s_rd, s_wr, s_wrdata, s_wrmask
    );

    modport slave (
        input  i_addr, i_rd, d_addr, d_rd, d_wr, d_wrdata, d_wrmask,
               s_hold, s_rddata, s_rddata_valid,
        output i_hold, i_rddata, i_rddata_valid, d_hold, d_rddata, d_rddata_valid,
               s_addr, s_rd, s_wr, s_wrdata, s_wrmask
    );
endinterface

// File: rtl/yari_mem_arbiter.sv
// Two-into-one memory arbiter for the yari core's I and D ports.
// D has priority, bounded by a starvation guard that yields to a waiting I
// after MAX_D_RUN consecutive D grants. The grant locks while the slave stalls.
// An in-order ID FIFO remembers the issuer of each accepted read so that read
// responses are steered back to it.
// Ports:
//   clock  : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : I/D core ports and shared memory port (slave view)
//   err    : sticky, set by a read response with no outstanding read
module yari_mem_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_D_RUN  = 4
) (
    input  logic              clock,
    input  logic              rst_n,
    yari_mem_arbiter_if.slave bus,
    output logic              err
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RUN_W = 4;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } grant_state_t;

    grant_state_t          grant_state, grant_state_nxt;
    logic [RUN_W-1:0]      d_run;
    logic [FIFO_DEPTH-1:0] id_fifo;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;

    logic i_req, d_req, fifo_empty, fifo_full, pop, read_block, i_ok, d_ok;
    logic grant_i, grant_d, present, accept, push, head;

    assign i_req      = bus.i_rd;
    assign d_req      = bus.d_rd | bus.d_wr;
    assign fifo_empty = (count == CNT_W'(0));
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = bus.s_rddata_valid & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a read may still go out when full.
    assign read_block = fifo_full & ~pop;
    assign i_ok       = i_req & ~read_block;
    assign d_ok       = bus.d_wr | (bus.d_rd & ~read_block);
    assign head       = id_fifo[rd_ptr];

    // Response steering: data is shared, valid follows the FIFO head.
    assign bus.i_rddata       = bus.s_rddata;
    assign bus.d_rddata       = bus.s_rddata;
    assign bus.i_rddata_valid = pop & ~head;
    assign bus.d_rddata_valid = pop & head;

    // Grant state register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            grant_state <= FREE;
        end else begin
            grant_state <= grant_state_nxt;
        end
    end

    // Winner selection, next grant state and slave-side request mux.
    always_comb begin
        grant_i         = 1'b0;
        grant_d         = 1'b0;
        present         = 1'b0;
        accept          = 1'b0;
        push            = 1'b0;
        grant_state_nxt = FREE;
        bus.s_addr      = '0;
        bus.s_rd        = 1'b0;
        bus.s_wr        = 1'b0;
        bus.s_wrdata    = '0;
        bus.s_wrmask    = '0;
        bus.i_hold      = 1'b0;
        bus.d_hold      = 1'b0;

        // Locked states ignore s_hold and competing requests entirely.
        case (grant_state)
            LOCK_I:  grant_i = 1'b1;
            LOCK_D:  grant_d = 1'b1;
            default: begin
                if (d_ok && !(i_ok && (d_run == RUN_W'(MAX_D_RUN)))) begin
                    grant_d = 1'b1;
                end else begin
                    grant_i = i_ok;
                end
            end
        endcase

        present = (grant_i & i_req) | (grant_d & d_req);
        accept  = present & ~bus.s_hold;
        push    = accept & (grant_i | bus.d_rd);

        if (present && bus.s_hold) begin
            grant_state_nxt = grant_d ? LOCK_D : LOCK_I;
        end

        if (grant_d) begin
            bus.s_addr   = bus.d_addr;
            bus.s_rd     = bus.d_rd;
            bus.s_wr     = bus.d_wr;
            bus.s_wrdata = bus.d_wrdata;
            bus.s_wrmask = bus.d_wrmask;
        end else if (grant_i) begin
            bus.s_addr   = bus.i_addr;
            bus.s_rd     = bus.i_rd;
        end

        bus.i_hold = i_req & (~grant_i | bus.s_hold);
        bus.d_hold = d_req & (~grant_d | bus.s_hold);
    end

    // Consecutive D grants seen by a waiting I; saturates at the guard limit.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            d_run <= '0;
        end else if (!i_req || (accept && grant_i)) begin
            d_run <= '0;
        end else if (accept && grant_d && (d_run != RUN_W'(MAX_D_RUN))) begin
            d_run <= d_run + RUN_W'(1);
        end
    end

    // Issuer ID FIFO (0 = I, 1 = D) and sticky orphan-response flag.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            id_fifo <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= grant_d;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (bus.s_rddata_valid && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end
endmodule
